// File: rtl/regfile_sb.sv
// Integer register file with NREAD combinational read ports, one write-back port,
// hardwired-zero x0 and a per-register busy scoreboard for RAW hazard detection.
module regfile_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NREAD      = 2,
    parameter int BYPASS     = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
    output logic [NREAD*DATA_WIDTH-1:0] rdata,
    output logic [NREAD-1:0]            rbusy,
    input  logic                        wen,
    input  logic [ADDR_WIDTH-1:0]       waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic                        iss_en,
    input  logic [ADDR_WIDTH-1:0]       iss_rd,
    output logic [ADDR_WIDTH:0]         busy_cnt,
    input  logic [ADDR_WIDTH-1:0]       dbg_addr,
    output logic [DATA_WIDTH-1:0]       dbg_data
);

    localparam int   DEPTH = 1 << ADDR_WIDTH;
    localparam logic BYP   = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] rf [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_next;
    logic [ADDR_WIDTH:0]   cnt_next;

    // A same-cycle issue overrides the retiring write-back: the issuer is younger.
    always_comb begin
        busy_next = '0;
        cnt_next  = '0;
        for (int r = 1; r < DEPTH; r++) begin
            if (iss_en && (iss_rd == ADDR_WIDTH'(r)))
                busy_next[r] = 1'b1;
            else if (wen && (waddr == ADDR_WIDTH'(r)))
                busy_next[r] = 1'b0;
            else
                busy_next[r] = busy[r];
            cnt_next = cnt_next + (ADDR_WIDTH + 1)'(busy_next[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++)
                rf[r] <= '0;
        end else if (wen && (waddr != '0)) begin
            rf[waddr] <= wdata;
        end
    end

    // Bypass is suppressed in reset so every read port reports zero while rst_n is low.
    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  byp;
        assign ra  = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign byp = BYP && rst_n && wen && (waddr == ra);
        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = (ra == '0) ? '0 : (byp ? wdata : rf[ra]);
        assign rbusy[i] = (ra != '0) && busy[ra] && !byp;
    end

    assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one BYPASS=1 and one BYPASS=0 instance share stimulus;
// an array-based reference model feeds a scoreboard checked at the falling edge.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  raddr = '0;
    logic        wen = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        iss_en = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic [4:0]  dbg_addr = '0;

    logic [63:0] rdata, rdata_nb;
    logic [1:0]  rbusy, rbusy_nb;
    logic [5:0]  busy_cnt, busy_cnt_nb;
    logic [31:0] dbg_data, dbg_data_nb;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(2), .BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_en(iss_en), .iss_rd(iss_rd),
        .busy_cnt(busy_cnt), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NREAD(2), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
        .wen(wen), .waddr(waddr), .wdata(wdata), .iss_en(iss_en), .iss_rd(iss_rd),
        .busy_cnt(busy_cnt_nb), .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
    );

    // Reference model: committed register contents and busy flags.
    logic [31:0] m_rf   [32];
    bit          m_busy [32];

    typedef struct {
        logic [31:0] rd0, rd1, rd0n, rd1n;
        logic [1:0]  rb, rbn;
        logic [5:0]  cnt;
        logic [31:0] dbg;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] ra, input bit byp);
        if (ra == 0) return 32'h0;
        if (byp && wen && waddr == ra) return wdata;
        return m_rf[ra];
    endfunction

    function automatic logic m_haz(input logic [4:0] ra, input bit byp);
        if (ra == 0) return 1'b0;
        return m_busy[ra] && !(byp && wen && waddr == ra);
    endfunction

    function automatic logic [5:0] m_count();
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(m_busy[r]);
        return 6'(c);
    endfunction

    task automatic m_clear();
        for (int r = 0; r < 32; r++) begin
            m_rf[r]   = 32'h0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Apply one cycle of stimulus, queue the expected response, advance the model.
    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ie, input logic [4:0] ir,
                         input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] da);
        exp_t e;
        wen = w; waddr = wa; wdata = wd;
        iss_en = ie; iss_rd = ir;
        raddr = {r1, r0}; dbg_addr = da;
        e.rd0  = m_read(r0, 1'b1);
        e.rd1  = m_read(r1, 1'b1);
        e.rd0n = m_read(r0, 1'b0);
        e.rd1n = m_read(r1, 1'b0);
        e.rb   = {m_haz(r1, 1'b1), m_haz(r0, 1'b1)};
        e.rbn  = {m_haz(r1, 1'b0), m_haz(r0, 1'b0)};
        e.cnt  = m_count();
        e.dbg  = m_rf[da];
        exp_q.push_back(e);
        if (w && wa != 0) begin
            m_rf[wa]   = wd;
            m_busy[wa] = 1'b0;
        end
        if (ie && ir != 0) m_busy[ir] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    // Monitor: outputs are combinational/registered, so every cycle with a queued
    // expectation is checked on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("rdata0",      {32'h0, rdata[31:0]},     {32'h0, e.rd0});
                check("rdata1",      {32'h0, rdata[63:32]},    {32'h0, e.rd1});
                check("rbusy",       {62'h0, rbusy},           {62'h0, e.rb});
                check("busy_cnt",    {58'h0, busy_cnt},        {58'h0, e.cnt});
                check("dbg_data",    {32'h0, dbg_data},        {32'h0, e.dbg});
                check("nb_rdata0",   {32'h0, rdata_nb[31:0]},  {32'h0, e.rd0n});
                check("nb_rdata1",   {32'h0, rdata_nb[63:32]}, {32'h0, e.rd1n});
                check("nb_rbusy",    {62'h0, rbusy_nb},        {62'h0, e.rbn});
                check("nb_busy_cnt", {58'h0, busy_cnt_nb},     {58'h0, e.cnt});
                check("nb_dbg_data", {32'h0, dbg_data_nb},     {32'h0, e.dbg});
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdata"},    rdata,                 64'h0);
        check({tag, "_rbusy"},    {62'h0, rbusy},        64'h0);
        check({tag, "_busy_cnt"}, {58'h0, busy_cnt},     64'h0);
        check({tag, "_dbg"},      {32'h0, dbg_data},     64'h0);
    endtask

    initial begin
        int guard;
        m_clear();
        @(posedge clk);
        #1;
        raddr = {5'd2, 5'd1}; dbg_addr = 5'd3;
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Write/read on both ports, then a dropped write to x0.
        drive(1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd3, 5'd3, 5'd3);
        drive(1, 5'd0, 32'h1234, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd3, 5'd0);

        // Bypass: x4 holds an old value while a new write lands this cycle.
        drive(1, 5'd4, 32'h11111111, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        drive(1, 5'd4, 32'hA5A5A5A5, 0, 5'd0, 5'd4, 5'd0, 5'd4);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd4, 5'd4, 5'd4);

        // Scoreboard set/clear on x9 and issue-vs-writeback collision on x12.
        drive(0, 5'd0, 32'h0, 1, 5'd9, 5'd0, 5'd0, 5'd0);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd1, 5'd0);
        drive(1, 5'd9, 32'h99, 0, 5'd0, 5'd9, 5'd9, 5'd9);
        drive(0, 5'd0, 32'h0, 1, 5'd12, 5'd9, 5'd12, 5'd9);
        drive(1, 5'd12, 32'hC0FFEE12, 1, 5'd12, 5'd12, 5'd0, 5'd12);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd12, 5'd12, 5'd12);
        check("x12_busy_kept", {63'h0, rbusy[0]}, 64'h1);
        drive(1, 5'd12, 32'h5, 0, 5'd0, 5'd0, 5'd0, 5'd0);

        // Fill the scoreboard: count saturates at 31 and an x0 issue is ignored.
        for (int r = 1; r < 32; r++)
            drive(0, 5'd0, 32'h0, 1, 5'(r), 5'(r), 5'd0, 5'd0);
        drive(0, 5'd0, 32'h0, 1, 5'd0, 5'd31, 5'd1, 5'd0);
        check("fill_cnt", {58'h0, busy_cnt}, 64'd31);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        check("fill_cnt_x0", {58'h0, busy_cnt}, 64'd31);

        // Asynchronous reset mid-run after writing x5 and issuing x7.
        drive(1, 5'd5, 32'h55555555, 1, 5'd7, 5'd0, 5'd0, 5'd0);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd7, 5'd5);
        wen = 1'b0; iss_en = 1'b0;
        #2;
        rst_n = 1'b0;
        m_clear();
        #1;
        check_reset_outputs("async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 5'd0, 32'h0, 0, 5'd0, 5'd5, 5'd7, 5'd5);
        check("post_rst_x5", {32'h0, rdata[31:0]}, 64'h0);

        // Randomized traffic with addresses biased toward collisions.
        for (int n = 0; n < 400; n++)
            drive(1'($urandom_range(0, 1)), rnd_addr(), $urandom(),
                  1'($urandom_range(0, 1)), rnd_addr(),
                  rnd_addr(), rnd_addr(), rnd_addr());

        wen = 1'b0; iss_en = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the NPC core, successor to the single-read/single-write file.
- Provides NREAD combinational read ports, one write-back port with optional same-cycle bypass, and a hardwired-zero register 0.
- Adds a per-register busy scoreboard: the decode stage marks destinations busy, write-back clears them, and read ports report RAW hazards.
- Includes a dedicated debug read port used by the simulation harness for register dumps.

Parameters:
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register width.
- NREAD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = read of a register being written this cycle returns wdata; 0 = returns the stored value.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- raddr  input  NREAD*ADDR_WIDTH  read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  output  NREAD*DATA_WIDTH  read data, packed the same way.
- rbusy  output  NREAD  port i's register is busy (hazard).
- wen  input  1  write-back enable.
- waddr  input  ADDR_WIDTH  write-back index.
- wdata  input  DATA_WIDTH  write-back data.
- iss_en  input  1  issue: mark iss_rd busy.
- iss_rd  input  ADDR_WIDTH  destination being issued.
- busy_cnt  output  ADDR_WIDTH+1  number of busy registers.
- dbg_addr  input  ADDR_WIDTH  debug read index.
- dbg_data  output  DATA_WIDTH  debug read data; never bypassed.

Behaviour:
- Reset: asynchronous, active-low.
  - While rst_n=0, all registers and all busy bits are 0.
  - Outputs: rdata = 0, rbusy = 0, busy_cnt = 0, dbg_data = 0.
  - Reset may assert mid-operation; every pending busy bit is lost, and the pipeline is flushed by the same reset.
- Storage:
  - Write: on posedge with wen=1 and waddr!=0, rf[waddr] <= wdata.
  - Writes to index 0 are dropped.
- Reads (combinational, zero latency):
  - raddr_i==0 gives rdata_i = 0 and rbusy_i = 0.
  - Otherwise, if BYPASS=1, wen=1 and waddr==raddr_i, rdata_i = wdata.
  - Otherwise rdata_i = rf[raddr_i].
  - Multiple ports reading the same index are all served.
- Scoreboard: busy[0] is always 0. Next-state per index r!=0:
  - set_r = iss_en and iss_rd==r.
  - clr_r = wen and waddr==r.
  - busy_next = set_r ? 1 : (clr_r ? 0 : busy).
  - Same-cycle issue and write-back to the same r: the new issue wins and busy stays 1, because the writer being retired is the older instruction.
  - Write-back to a non-busy register: data is written and busy is unchanged (still 0). This is not an error.
  - Issue to an already-busy register: busy stays 1 (WAW is the issue stage's responsibility).
- Hazard output:
  - rbusy_i = busy[raddr_i] & ~(BYPASS & wen & waddr==raddr_i).
  - With BYPASS=1, a write-back landing this cycle satisfies the hazard.
- busy_cnt:
  - Registered population count of busy bits; updated in the same cycle the bits change.
  - Maximum value is 2**ADDR_WIDTH-1; no wrap.
- Debug port:
  - dbg_data = rf[dbg_addr] (0 for index 0). It reflects committed state only.
  - It has no effect on any other output.

Test Plan:
- Reset with rst_n=0 mid-run after writes to x5 and an issue of x7 → rdata = 0, rbusy = 0, busy_cnt = 0 immediately (asynchronous); after release, a read of x5 returns 0.
- Write x3=0xDEADBEEF, then read on ports 0 and 1 with raddr=3 → both return 0xDEADBEEF the next cycle. Write x0=0x1234 → reading x0 returns 0, busy_cnt unchanged.
- BYPASS=1: in the same cycle wen=1, waddr=4, wdata=0xA5A5A5A5, raddr0=4 → rdata0 = 0xA5A5A5A5 combinationally, with rf[4] holding its old value until the edge. BYPASS=0 → rdata0 shows the old value.
- Scoreboard:
  - Issue x9 → rbusy = 1 for port reading 9, busy_cnt = 1.
  - Write-back x9 → the same cycle shows rbusy = 0 (BYPASS=1); after the edge, busy_cnt = 0.
- Simultaneous iss_en and wen both to x12 while x12 is busy → busy stays 1, busy_cnt unchanged, rf[12] = wdata.
- Issue x1..x31 on consecutive cycles → busy_cnt reaches 31 with no wrap. Issue x0 → no change.
